pool_requant: RTL
=================

POOL_REQUANT -- requirements
Module: pool_requant

Interface
REQ-001 Parameter MAPSIZE, default 28: side length of the square convolution result map held in BRAM; SHALL be even and >= 2.
REQ-002 Parameter SHIFT_W, default 5: width of the requantisation shift input.
REQ-003 clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 start  input  1: begin one pass over the result map; sampled only in IDLE.
REQ-006 mem_rd_addr  output  $clog2(MAPSIZE*MAPSIZE): BRAM read address, row-major (row*MAPSIZE+col).
REQ-007 mem_rd_en  output  1: BRAM read strobe.
REQ-008 mem_rd_data  input  32 signed: BRAM read data, valid exactly 1 cycle after the mem_rd_en cycle.
REQ-009 bias  input  32 signed: per-channel bias, held stable for the whole pass.
REQ-010 shift  input  SHIFT_W: arithmetic right-shift amount, held stable for the whole pass.
REQ-011 pixel_out  output  8 signed: pooled, requantised pixel, range 0..127.
REQ-012 data_valid_out  output  1: pixel_out valid this cycle; drives the next convolution stage's streaming input directly, no backpressure.
REQ-013 all_done  output  1: one-cycle pulse after the final pixel is emitted.

Function
REQ-014 FSM states IDLE, READ, DRAIN, DONE; IDLE->READ on start; READ->DRAIN after the last read is issued; DRAIN->DONE when no pooled result remains in flight; DONE->IDLE unconditionally after one cycle.
REQ-015 In READ, one read per cycle, mem_rd_en high every cycle; each 2x2 window (2r,2c),(2r,2c+1),(2r+1,2c),(2r+1,2c+1) is read in that order.
REQ-016 Windows SHALL be visited row-major: c = 0..MAPSIZE/2-1 inner, r = 0..MAPSIZE/2-1 outer; read phase lasts exactly MAPSIZE*MAPSIZE cycles.
REQ-017 Running max of the 4 returned 32-bit signed values SHALL be kept per window; the first value of a window replaces, never compares against, the previous window's max.
REQ-018 Requantisation on the window max m: s = m + bias computed at 33 bits; s < 0 -> 0; else s >>> shift; result > 127 -> 127; output low 8 bits.
REQ-019 Latency: pixel_out/data_valid_out SHALL be registered and assert exactly 2 cycles after the cycle issuing the window's 4th read.
REQ-020 data_valid_out SHALL pulse one cycle per window, every 4 cycles; exactly (MAPSIZE/2)^2 pulses per pass; pixel_out holds its last value when not valid.
REQ-021 all_done SHALL assert the cycle after the final data_valid_out, for one cycle, in DONE.
REQ-022 start while not in IDLE SHALL be ignored; start in DONE SHALL NOT be honoured until IDLE.
REQ-023 Outside READ, mem_rd_en SHALL be 0; mem_rd_addr is don't-care when mem_rd_en is 0.
REQ-024 bias/shift changes mid-pass are undefined behaviour; block SHALL NOT latch them.

Reset
REQ-025 rst SHALL force IDLE and clear mem_rd_en, data_valid_out, all_done, pixel_out, mem_rd_addr, all counters and the in-flight pipeline in the same edge.
REQ-026 rst mid-pass SHALL abort with no further valid or done pulses; next start begins a fresh pass at address 0.

Structure
REQ-027 FSM state enum and the requant saturation constant (127) SHALL live in the shared accelerator package.
REQ-028 Requantisation (REQ-018) SHALL be one combinational sub-module, requant_relu_sat, reused by later layers.

Verification
REQ-029 MAPSIZE=4, map values 0..15 row-major, bias=0, shift=0 -> 4 outputs 5,7,13,15; 4 valid pulses 4 cycles apart; all_done 1 cycle after last.
REQ-030 MAPSIZE=4, all values -100, bias=50 -> 4 outputs of 0 (ReLU).
REQ-031 MAPSIZE=2, values {1000,-5,3,200}, bias=24, shift=3 -> single output 127 (1024>>>3=128 saturated); same with shift=4 -> 64.
REQ-032 MAPSIZE=28, random BRAM image vs. software model -> 196 outputs bit-exact; first valid 2 cycles after 4th mem_rd_en; 784 read cycles total.
REQ-033 rst asserted after 2nd output, then start -> no pulses until restart; restarted pass reads from address 0 and matches model.
REQ-034 start pulsed repeatedly mid-pass -> address sequence and output count unchanged.

Source files
------------

// File: rtl/pool_requant_pkg.sv
// Shared accelerator package: pooling FSM states, datapath widths and the
// requantisation saturation limit.
package pool_requant_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PIX_W  = 8;

  localparam logic signed [PIX_W-1:0] SAT_MAX = PIX_W'(127);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } pool_state_e;

  // Tag that travels with each BRAM read until its data returns.
  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } rd_tag_t;

endpackage

// File: rtl/pool_requant_if.sv
// BRAM read port plus the pooled pixel stream, bundled for pool_requant.
interface pool_requant_if #(
  parameter int unsigned ADDR_W = 10
);
  import pool_requant_pkg::*;

  logic [ADDR_W-1:0]        mem_rd_addr;
  logic                     mem_rd_en;
  logic signed [DATA_W-1:0] mem_rd_data;
  logic signed [PIX_W-1:0]  pixel_out;
  logic                     data_valid_out;
  logic                     all_done;

  modport master (
    output mem_rd_addr,
    output mem_rd_en,
    input  mem_rd_data,
    output pixel_out,
    output data_valid_out,
    output all_done
  );

  modport slave (
    input  mem_rd_addr,
    input  mem_rd_en,
    output mem_rd_data,
    input  pixel_out,
    input  data_valid_out,
    input  all_done
  );

endinterface

// File: rtl/pool_requant_relu_sat.sv
// Combinational requantisation: add bias at 33 bits, ReLU, arithmetic shift,
// saturate to 127. Shared with later layers.
module requant_relu_sat
  import pool_requant_pkg::*;
#(
  parameter int unsigned SHIFT_W = 5
) (
  input  logic signed [DATA_W-1:0] max_i,
  input  logic signed [DATA_W-1:0] bias_i,
  input  logic [SHIFT_W-1:0]       shift_i,
  output logic signed [PIX_W-1:0]  pixel_c_o
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic signed [SUM_W-1:0] sum_c;
  logic signed [SUM_W-1:0] shr_c;

  always_comb begin
    sum_c     = SUM_W'(max_i) + SUM_W'(bias_i);
    shr_c     = sum_c >>> shift_i;
    pixel_c_o = '0;
    if (sum_c[SUM_W-1]) begin
      pixel_c_o = '0;
    end else if (shr_c > SUM_W'(SAT_MAX)) begin
      pixel_c_o = SAT_MAX;
    end else begin
      pixel_c_o = PIX_W'(shr_c);
    end
  end

endmodule

// File: rtl/pool_requant.sv
// 2x2 max-pool over a square BRAM result map followed by bias/shift/ReLU
// requantisation; streams one pixel per window to the next layer.
module pool_requant
  import pool_requant_pkg::*;
#(
  parameter int unsigned MAPSIZE = 28,
  parameter int unsigned SHIFT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] bias,
  input  logic [SHIFT_W-1:0]       shift,
  pool_requant_if.master           bus
);

  localparam int unsigned ADDR_W = $clog2(MAPSIZE * MAPSIZE);
  localparam int unsigned HALF   = MAPSIZE / 2;
  localparam int unsigned CNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  pool_state_e              state_q, state_d;
  logic [CNT_W-1:0]         r_q, r_d;
  logic [CNT_W-1:0]         c_q, c_d;
  logic [1:0]               k_q, k_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     en_q, en_d;
  rd_tag_t                  tag_q, tag_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic signed [PIX_W-1:0]  pix_q, pix_d;
  logic                     vld_q, vld_d;
  logic                     done_q, done_d;

  logic                     last_rd_c;
  logic signed [DATA_W-1:0] win_max_c;
  logic signed [PIX_W-1:0]  rq_pix_c;

  // Row-major address of element k (0..3) inside window (r, c).
  function automatic logic [ADDR_W-1:0] win_addr(input logic [CNT_W-1:0] r,
                                                 input logic [CNT_W-1:0] c,
                                                 input logic [1:0]       k);
    logic [CNT_W:0] row;
    logic [CNT_W:0] col;
    row = {r, k[1]};
    col = {c, k[0]};
    return ADDR_W'(32'(row) * MAPSIZE + 32'(col));
  endfunction

  requant_relu_sat #(
    .SHIFT_W (SHIFT_W)
  ) u_requant (
    .max_i     (win_max_c),
    .bias_i    (bias),
    .shift_i   (shift),
    .pixel_c_o (rq_pix_c)
  );

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    addr_d    = addr_q;
    en_d      = 1'b0;
    last_rd_c = (k_q == 2'd3) && (c_q == CNT_LAST) && (r_q == CNT_LAST);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          en_d    = 1'b1;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          addr_d  = '0;
        end
      end
      READ: begin
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          if (c_q == CNT_LAST) begin
            c_d = '0;
            r_d = r_q + CNT_W'(1);
          end else begin
            c_d = c_q + CNT_W'(1);
          end
        end
        if (last_rd_c) begin
          state_d = DRAIN;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
        end else begin
          en_d   = 1'b1;
          addr_d = win_addr(r_d, c_d, k_d);
        end
      end
      // Wait until the last window's data has come back from BRAM.
      DRAIN: begin
        if (!tag_q.vld) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    done_d = (state_d == DONE);

    tag_d.vld   = en_q;
    tag_d.first = en_q && (k_q == 2'd0);
    tag_d.last  = en_q && (k_q == 2'd3);

    // First value of a window replaces the previous window's max outright.
    win_max_c = (tag_q.first || (bus.mem_rd_data > max_q)) ? bus.mem_rd_data : max_q;
    max_d     = tag_q.vld ? win_max_c : max_q;
    vld_d     = tag_q.vld && tag_q.last;
    pix_d     = vld_d ? rq_pix_c : pix_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      tag_q   <= '0;
      max_q   <= '0;
      pix_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
      tag_q   <= tag_d;
      max_q   <= max_d;
      pix_q   <= pix_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_rd_addr    = addr_q;
  assign bus.mem_rd_en      = en_q;
  assign bus.pixel_out      = pix_q;
  assign bus.data_valid_out = vld_q;
  assign bus.all_done       = done_q;

endmodule
